// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for the multicycle RV32I-subset core. Sequences the shared
//   datapath (ALU, regfile, immediate generator, PC/IR/ALUOut/MDR and one
//   unified memory port) across several cycles per instruction, decodes the
//   latched instruction, and handshakes with a variable-latency memory.
//
//   Optional feature: define MULTICYCLE_CTRL_INSTRET_EN to build the
//   retired-instruction counter; otherwise instret is tied to 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   instr[31:0]     IR contents (valid from DECODE onward)
//   zero            ALU equality flag (a == b)
//   mem_ready       memory completes the outstanding request this cycle
//   mem_req/mem_we  memory request / store
//   iord            memory address select (0 PC, 1 ALUOut)
//   ir_we           load IR and MDR from memory data
//   pc_we, pc_sel   PC write, PC source (0 ALU result, 1 ALUOut)
//   reg_we, wb_sel  regfile write, write-back source (0 ALUOut, 1 MDR, 2 PC)
//   alu_a_sel       0 PC, 1 oldPC, 2 rs1, 3 zero
//   alu_b_sel       0 rs2, 1 const 4, 2 imm
//   ula_op          0 add, 1 sub, 2 and, 3 or, 4 slt
//   halted          illegal instruction seen
//   state           current state (debug)
//   instret         retired-instruction count
//
// state    | meaning
// ---------+---------------------------------------------------------
// START    | first cycle after reset, all outputs idle
// FETCH    | read instruction at PC, PC <= PC + 4 on completion
// DECODE   | ALUOut <= oldPC + imm (branch/jal target), dispatch
// MEMADDR  | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory, MDR captured on completion
// MEMWB    | rd <= MDR
// MEMWRITE | write data memory
// EXEC     | R-type / I-type / LUI operation into ALUOut
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1 - rs2, PC <= ALUOut if taken
// JAL      | rd <= PC (already pc+4), PC <= ALUOut
// JALR     | rd <= PC, PC <= rs1 + imm
// HALT     | illegal instruction, terminal until reset

module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [4:0]  ula_op,
    output logic        halted,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;

    localparam logic [1:0] A_PC    = 2'd0;
    localparam logic [1:0] A_OLDPC = 2'd1;
    localparam logic [1:0] A_RS1   = 2'd2;
    localparam logic [1:0] A_ZERO  = 2'd3;

    localparam logic [1:0] B_RS2   = 2'd0;
    localparam logic [1:0] B_FOUR  = 2'd1;
    localparam logic [1:0] B_IMM   = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    // EXEC-stage operation decode, shared by the EXEC output setup and the
    // EXEC legality check.
    logic       exec_legal;
    logic [4:0] exec_op;
    logic [1:0] exec_a;
    logic [1:0] exec_b;

    always_comb begin
        exec_legal = 1'b0;
        exec_op    = ALU_ADD;
        exec_a     = A_RS1;
        exec_b     = B_RS2;
        case (opcode)
            OPC_RTYPE: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin exec_legal = 1'b1; exec_op = ALU_ADD; end
                    {7'b0100000, 3'b000}: begin exec_legal = 1'b1; exec_op = ALU_SUB; end
                    {7'b0000000, 3'b111}: begin exec_legal = 1'b1; exec_op = ALU_AND; end
                    {7'b0000000, 3'b110}: begin exec_legal = 1'b1; exec_op = ALU_OR;  end
                    {7'b0000000, 3'b010}: begin exec_legal = 1'b1; exec_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OPC_ITYPE: begin
                exec_b = B_IMM;
                case (funct3)
                    3'b000: begin exec_legal = 1'b1; exec_op = ALU_ADD; end
                    3'b111: begin exec_legal = 1'b1; exec_op = ALU_AND; end
                    3'b110: begin exec_legal = 1'b1; exec_op = ALU_OR;  end
                    3'b010: begin exec_legal = 1'b1; exec_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                exec_legal = 1'b1;
                exec_a     = A_ZERO;
                exec_b     = B_IMM;
            end
            default: ;
        endcase
    end

    state_t     state_q, state_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       iord_q, iord_d;
    logic       fetch_q, fetch_d;     // in FETCH: enables the Mealy ir_we/pc_we
    logic       pc_we_q, pc_we_d;     // unconditional PC write (JAL/JALR)
    logic       br_eq_q, br_eq_d;     // BRANCH beq: write PC when zero
    logic       br_ne_q, br_ne_d;     // BRANCH bne: write PC when !zero
    logic       pc_sel_q, pc_sel_d;
    logic       reg_we_q, reg_we_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic [1:0] alu_a_q, alu_a_d;
    logic [1:0] alu_b_q, alu_b_d;
    logic [4:0] ula_op_q, ula_op_d;
    logic       halted_q, halted_d;

    // Outputs are registered from the next state, so every Moore output is
    // a flop and all of them clear asynchronously with rst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:   state_d = S_FETCH;
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE:         state_d = S_MEMADDR;
                    OPC_RTYPE, OPC_ITYPE, OPC_LUI: state_d = S_EXEC;
                    OPC_BRANCH:                  state_d = S_BRANCH;
                    OPC_JAL:                     state_d = S_JAL;
                    OPC_JALR:                    state_d = S_JALR;
                    default:                     state_d = S_HALT;
                endcase
            end
            S_MEMADDR:  state_d = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = exec_legal ? S_ALUWB : S_HALT;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_HALT;
            S_JAL:      state_d = S_FETCH;
            S_JALR:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_START;
        endcase

        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        iord_d    = 1'b0;
        fetch_d   = 1'b0;
        pc_we_d   = 1'b0;
        br_eq_d   = 1'b0;
        br_ne_d   = 1'b0;
        pc_sel_d  = 1'b0;
        reg_we_d  = 1'b0;
        wb_sel_d  = WB_ALUOUT;
        alu_a_d   = A_PC;
        alu_b_d   = B_RS2;
        ula_op_d  = ALU_ADD;
        halted_d  = 1'b0;
        case (state_d)
            S_FETCH: begin
                mem_req_d = 1'b1;
                fetch_d   = 1'b1;
                alu_a_d   = A_PC;
                alu_b_d   = B_FOUR;
            end
            S_DECODE: begin
                alu_a_d = A_OLDPC;
                alu_b_d = B_IMM;
            end
            S_MEMADDR: begin
                alu_a_d = A_RS1;
                alu_b_d = B_IMM;
            end
            S_MEMREAD: begin
                mem_req_d = 1'b1;
                iord_d    = 1'b1;
            end
            S_MEMWB: begin
                reg_we_d = 1'b1;
                wb_sel_d = WB_MDR;
            end
            S_MEMWRITE: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                iord_d    = 1'b1;
            end
            S_EXEC: begin
                alu_a_d  = exec_a;
                alu_b_d  = exec_b;
                ula_op_d = exec_op;
            end
            S_ALUWB: begin
                reg_we_d = 1'b1;
                wb_sel_d = WB_ALUOUT;
            end
            S_BRANCH: begin
                alu_a_d  = A_RS1;
                alu_b_d  = B_RS2;
                ula_op_d = ALU_SUB;
                pc_sel_d = 1'b1;
                br_eq_d  = (funct3 == 3'b000);
                br_ne_d  = (funct3 == 3'b001);
            end
            S_JAL: begin
                reg_we_d = 1'b1;
                wb_sel_d = WB_PC;
                pc_we_d  = 1'b1;
                pc_sel_d = 1'b1;
            end
            S_JALR: begin
                alu_a_d  = A_RS1;
                alu_b_d  = B_IMM;
                pc_we_d  = 1'b1;
                reg_we_d = 1'b1;
                wb_sel_d = WB_PC;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_START;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            iord_q    <= 1'b0;
            fetch_q   <= 1'b0;
            pc_we_q   <= 1'b0;
            br_eq_q   <= 1'b0;
            br_ne_q   <= 1'b0;
            pc_sel_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            wb_sel_q  <= 2'd0;
            alu_a_q   <= 2'd0;
            alu_b_q   <= 2'd0;
            ula_op_q  <= 5'd0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            iord_q    <= iord_d;
            fetch_q   <= fetch_d;
            pc_we_q   <= pc_we_d;
            br_eq_q   <= br_eq_d;
            br_ne_q   <= br_ne_d;
            pc_sel_q  <= pc_sel_d;
            reg_we_q  <= reg_we_d;
            wb_sel_q  <= wb_sel_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            ula_op_q  <= ula_op_d;
            halted_q  <= halted_d;
        end
    end

    // ir_we and the FETCH PC write complete with the memory handshake; the
    // branch PC write follows the ALU compare of the same cycle.
    assign ir_we     = fetch_q & mem_ready;
    assign pc_we     = pc_we_q | (fetch_q & mem_ready) | (br_eq_q & zero) | (br_ne_q & ~zero);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign iord      = iord_q;
    assign pc_sel    = pc_sel_q;
    assign reg_we    = reg_we_q;
    assign wb_sel    = wb_sel_q;
    assign alu_a_sel = alu_a_q;
    assign alu_b_sel = alu_b_q;
    assign ula_op    = ula_op_q;
    assign halted    = halted_q;
    assign state     = state_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q, instret_d;
    logic        retire;

    // An instruction retires on its last cycle, i.e. on the step back into
    // FETCH; the path into HALT never counts.
    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_MEMWB  || state_q == S_MEMWRITE || state_q == S_ALUWB ||
                     state_q == S_BRANCH || state_q == S_JAL      || state_q == S_JALR);

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret_q <= 32'd0;
        else     instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_we, pc_we, pc_sel, reg_we, halted;
    logic [1:0]  wb_sel, alu_a_sel, alu_b_sel;
    logic [4:0]  ula_op;
    logic [3:0]  state;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .ula_op(ula_op),
        .halted(halted), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam int ST_START = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADDR = 3,
                   ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXEC = 7,
                   ST_ALUWB = 8, ST_BRANCH = 9, ST_JAL = 10, ST_JALR = 11, ST_HALT = 12;

    // Packed observation: {state, mem_req, mem_we, iord, ir_we, pc_we, pc_sel,
    // reg_we, wb_sel, alu_a_sel, alu_b_sel, ula_op, halted}
    logic [22:0] act_vec;
    assign act_vec = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_sel, reg_we,
                      wb_sel, alu_a_sel, alu_b_sel, ula_op, halted};

    typedef struct {
        logic [22:0] exp;
        logic [22:0] mask;
        logic [31:0] instret;
    } rec_t;

    rec_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_ret = 32'd0;

    function automatic logic [31:0] exp_ret();
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        return model_ret;
`else
        return 32'd0;
`endif
    endfunction

    // Instruction-set view of the EXEC step: which operation the instruction names.
    function automatic void alu_model(input logic [31:0] ins, output bit legal,
                                      output logic [4:0] op, output logic [1:0] a,
                                      output logic [1:0] b);
        logic [9:0] key;
        key   = {ins[31:25], ins[14:12]};
        legal = 1'b0; op = 5'd0; a = 2'd2; b = 2'd0;
        if (ins[6:0] == 7'b0110011) begin
            b = 2'd0;
            if      (key == 10'b0000000_000) begin legal = 1; op = 5'd0; end
            else if (key == 10'b0100000_000) begin legal = 1; op = 5'd1; end
            else if (key == 10'b0000000_111) begin legal = 1; op = 5'd2; end
            else if (key == 10'b0000000_110) begin legal = 1; op = 5'd3; end
            else if (key == 10'b0000000_010) begin legal = 1; op = 5'd4; end
        end else if (ins[6:0] == 7'b0010011) begin
            b = 2'd2;
            if      (ins[14:12] == 3'b000) begin legal = 1; op = 5'd0; end
            else if (ins[14:12] == 3'b111) begin legal = 1; op = 5'd2; end
            else if (ins[14:12] == 3'b110) begin legal = 1; op = 5'd3; end
            else if (ins[14:12] == 3'b010) begin legal = 1; op = 5'd4; end
        end else if (ins[6:0] == 7'b0110111) begin
            legal = 1; a = 2'd3; b = 2'd2; op = 5'd0;
        end
    endfunction

    function automatic void exp_of(input int ph, input logic [31:0] ins, input bit rdy,
                                   input bit z, output logic [22:0] e, output logic [22:0] m);
        logic mreq, mwe, io, irw, pcw, psel, rwe, hlt, legal;
        logic [1:0] wb, a, b;
        logic [4:0] op;
        mreq = 0; mwe = 0; io = 0; irw = 0; pcw = 0; psel = 0; rwe = 0; hlt = 0;
        wb = 0; a = 0; b = 0; op = 0;
        m = '1;
        case (ph)
            ST_FETCH:    begin mreq = 1; a = 0; b = 1; irw = rdy; pcw = rdy; end
            ST_DECODE:   begin a = 1; b = 2; end
            ST_MEMADDR:  begin a = 2; b = 2; end
            ST_MEMREAD:  begin mreq = 1; io = 1; end
            ST_MEMWB:    begin rwe = 1; wb = 1; end
            ST_MEMWRITE: begin mreq = 1; mwe = 1; io = 1; end
            ST_EXEC: begin
                alu_model(ins, legal, op, a, b);
                if (!legal) begin
                    a = 0; b = 0; op = 0;
                    m[9:1] = 9'd0;
                end
            end
            ST_ALUWB:    begin rwe = 1; wb = 0; end
            ST_BRANCH: begin
                a = 2; b = 0; op = 1; psel = 1;
                if      (ins[14:12] == 3'b000) pcw = z;
                else if (ins[14:12] == 3'b001) pcw = !z;
                else begin pcw = 0; psel = 0; m[13] = 1'b0; end
            end
            ST_JAL:      begin rwe = 1; wb = 2; pcw = 1; psel = 1; end
            ST_JALR:     begin a = 2; b = 2; op = 0; pcw = 1; psel = 0; rwe = 1; wb = 2; end
            ST_HALT:     hlt = 1;
            default: ;
        endcase
        e = {4'(ph), mreq, mwe, io, irw, pcw, psel, rwe, wb, a, b, op, hlt};
    endfunction

    // Monitor: one expected record per cycle the stimulus drove out of reset.
    always @(negedge clk) begin
        rec_t r;
        if (!rst && sb_q.size() > 0) begin
            r = sb_q.pop_front();
            n_tests++;
            if ((act_vec & r.mask) !== r.exp) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h care=%h", $time, act_vec & r.mask, r.exp, r.mask);
            end
            n_tests++;
            if (instret !== r.instret) begin
                n_fail++;
                $display("FAIL cycle_instret t=%0t actual=%0d required=%0d", $time, instret, r.instret);
            end
        end
    end

    // Entered and left at one time unit after a rising edge.
    task automatic step(input int ph, input logic [31:0] ins, input bit rdy, input bit z);
        rec_t r;
        logic [22:0] e, m;
        exp_of(ph, ins, rdy, z, e, m);
        r.exp = e; r.mask = m; r.instret = exp_ret();
        sb_q.push_back(r);
        mem_ready = rdy;
        zero      = (ph == ST_BRANCH) ? z : 1'($urandom);
        instr     = (ph == ST_FETCH) ? $urandom : ins;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit z,
                             input int cut, input int hc);
        int ph[$];
        bit rd[$];
        bit retire, legal;
        int mst, n;
        logic [4:0] op;
        logic [1:0] a, b;
        retire = 1;
        for (int i = 0; i < fw; i++) begin ph.push_back(ST_FETCH); rd.push_back(0); end
        ph.push_back(ST_FETCH);  rd.push_back(1);
        ph.push_back(ST_DECODE); rd.push_back(1'($urandom));
        case (ins[6:0])
            7'b0000011, 7'b0100011: begin
                ph.push_back(ST_MEMADDR); rd.push_back(1'($urandom));
                mst = (ins[6:0] == 7'b0000011) ? ST_MEMREAD : ST_MEMWRITE;
                for (int i = 0; i < mw; i++) begin ph.push_back(mst); rd.push_back(0); end
                ph.push_back(mst); rd.push_back(1);
                if (mst == ST_MEMREAD) begin ph.push_back(ST_MEMWB); rd.push_back(1'($urandom)); end
            end
            7'b0110011, 7'b0010011, 7'b0110111: begin
                alu_model(ins, legal, op, a, b);
                ph.push_back(ST_EXEC); rd.push_back(1'($urandom));
                if (legal) begin ph.push_back(ST_ALUWB); rd.push_back(1'($urandom)); end
                else retire = 0;
            end
            7'b1100011: begin
                ph.push_back(ST_BRANCH); rd.push_back(1'($urandom));
                if (ins[14:13] != 2'b00) retire = 0;
            end
            7'b1101111: begin ph.push_back(ST_JAL);  rd.push_back(1'($urandom)); end
            7'b1100111: begin ph.push_back(ST_JALR); rd.push_back(1'($urandom)); end
            default: retire = 0;
        endcase
        if (!retire)
            for (int i = 0; i < hc; i++) begin ph.push_back(ST_HALT); rd.push_back(1'($urandom)); end
        n = (cut >= 0) ? cut : ph.size();
        for (int k = 0; k < n; k++) step(ph[k], ins, rd[k], z);
        if (retire && cut < 0) model_ret++;
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (act_vec !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs actual=%h required=%h", act_vec, 23'd0);
        end
        n_tests++;
        if (instret !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_instret actual=%0d required=0", instret);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_ret = 32'd0;
        step(ST_START, $urandom, 1'($urandom), 1'($urandom));
    endtask

    function automatic logic [31:0] rand_legal();
        int k, j;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] w;
        k = $urandom_range(0, 8);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        w = 32'd0;
        case (k)
            0: w = {12'($urandom), rs1, 3'b010, rd, 7'b0000011};
            1: w = {7'($urandom), rs2, rs1, 3'b010, 5'($urandom), 7'b0100011};
            2: begin
                j = $urandom_range(0, 4);
                f7 = (j == 1) ? 7'b0100000 : 7'b0000000;
                f3 = (j <= 1) ? 3'b000 : (j == 2) ? 3'b111 : (j == 3) ? 3'b110 : 3'b010;
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            3: begin
                j = $urandom_range(0, 3);
                f3 = (j == 0) ? 3'b000 : (j == 1) ? 3'b111 : (j == 2) ? 3'b110 : 3'b010;
                w = {12'($urandom), rs1, f3, rd, 7'b0010011};
            end
            4: w = {20'($urandom), rd, 7'b0110111};
            5: w = {7'($urandom), rs2, rs1, 3'b000, 5'($urandom), 7'b1100011};
            6: w = {7'($urandom), rs2, rs1, 3'b001, 5'($urandom), 7'b1100011};
            7: w = {20'($urandom), rd, 7'b1101111};
            default: w = {12'($urandom), rs1, 3'b000, rd, 7'b1100111};
        endcase
        return w;
    endfunction

    logic [31:0] illegal_set [4] = '{32'h0000007F, 32'h02208033, 32'h0020C463, 32'h00109093};

    initial begin
        @(posedge clk); #1;
        do_reset();

        run_instr(32'h00500093, 0, 0, 0, -1, 0);   // addi x1,x0,5
        run_instr(32'h0000A103, 0, 3, 0, -1, 0);   // lw x2,0(x1), 3 wait cycles
        run_instr(32'h00000463, 0, 0, 1, -1, 0);   // beq x0,x0,+8 taken
        run_instr(32'h00001463, 0, 0, 1, -1, 0);   // bne not taken
        run_instr(32'h00001463, 1, 0, 0, -1, 0);   // bne taken, fetch wait
        run_instr(32'h000080E7, 0, 0, 0, -1, 0);   // jalr x1,0(x1)
        run_instr(32'h008000EF, 0, 0, 0, -1, 0);   // jal x1,+8
        run_instr(32'h0020A023, 2, 2, 0, -1, 0);   // sw with waits

        for (int i = 0; i < 40; i++)
            run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), -1, 0);

        for (int i = 0; i < 4; i++) begin
            run_instr(illegal_set[i], $urandom_range(0, 1), 0, 1'($urandom), -1, 6);
            do_reset();
            run_instr(rand_legal(), 0, $urandom_range(0, 2), 1'($urandom), -1, 0);
            run_instr(rand_legal(), 1, $urandom_range(0, 2), 1'($urandom), -1, 0);
        end

        // Reset while a store is still waiting on memory.
        run_instr(32'h0020A023, 0, 3, 0, 4, 0);
        do_reset();
        run_instr(32'h00500093, 0, 0, 0, -1, 0);
        run_instr(32'h0000A103, 1, 1, 0, -1, 0);

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I-subset core. It sequences the shared datapath (ALU, regfile, immediate generator, PC/IR/ALUOut/MDR registers, a single unified memory port) over several cycles per instruction. It decodes the latched instruction, drives every datapath select and write enable, and handshakes with a variable-latency memory.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr  in  32  IR contents; valid from DECODE onward
- zero  in  1  ALU equality flag (operands a == b)
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write request (store)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  load IR and MDR from memory data
- pc_we  out  1  PC write
- pc_sel  out  1  PC source: 0 = ALU result, 1 = ALUOut
- reg_we  out  1  regfile write (rd taken from instr[11:7])
- wb_sel  out  2  write-back data: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_a_sel  out  2  0 = PC, 1 = oldPC, 2 = rs1, 3 = 32'b0
- alu_b_sel  out  2  0 = rs2, 1 = 32'd4, 2 = imm
- ula_op  out  5  00000 add, 00001 sub, 00010 and, 00011 or, 00100 slt (signed)
- halted  out  1  illegal instruction seen
- state  out  4  current state encoding (debug)
- instret  out  32  retired-instruction count (see Configuration)

## Operation
- State encodings: START=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXEC=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, HALT=12.
- Any output not listed for a state is 0.
- START: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, iord=0, alu_a_sel=PC, alu_b_sel=4, add.
  - When mem_ready=1: ir_we=1, pc_we=1, pc_sel=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_a_sel=oldPC, alu_b_sel=imm, add. Result (branch/jal target) lands in ALUOut.
  - Dispatch on opcode:
    - 0000011 / 0100011 → MEMADDR
    - 0110011 / 0010011 / 0110111 → EXEC
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - anything else → HALT
- MEMADDR: rs1 + imm, add. Next state MEMREAD if load, MEMWRITE if store.
- MEMREAD: mem_req=1, iord=1, mem_we=0. When mem_ready=1: ir_we=0, MDR captured, next state MEMWB.
- MEMWB: reg_we=1, wb_sel=MDR. Next state FETCH.
- MEMWRITE: mem_req=1, mem_we=1, iord=1. When mem_ready=1: next state FETCH.
- EXEC:
  - R-type: rs1 op rs2. Legal {funct7,funct3} pairs:
    - 0000000/000 add
    - 0100000/000 sub
    - 0000000/111 and
    - 0000000/110 or
    - 0000000/010 slt
  - I-type: rs1 op imm. funct3 000 add, 111 and, 110 or, 010 slt.
  - LUI: 0 + imm, add.
  - Illegal funct → HALT; otherwise → ALUWB.
- ALUWB: reg_we=1, wb_sel=ALUOut. Next state FETCH.
- BRANCH: rs1 − rs2, sub.
  - funct3 000 (beq): taken when zero=1.
  - funct3 001 (bne): taken when zero=0.
  - Other funct3 → HALT.
  - Taken: pc_we=1, pc_sel=ALUOut.
  - Next state FETCH.
- JAL: reg_we=1, wb_sel=PC (PC already holds pc+4), pc_we=1, pc_sel=ALUOut. Next state FETCH.
- JALR: rs1 + imm, add; pc_we=1, pc_sel=ALU result; reg_we=1, wb_sel=PC. Next state FETCH.
  - The datapath clears bit 0 of the new PC.
  - rd == rs1 is legal: the regfile reads the old value combinationally.
- HALT: halted=1, all enables 0. Terminal until rst.

## Timing
- Reset: state=START, and every output is 0, including instret.
- The first memory request is asserted one cycle after rst deasserts.
- Memory handshake:
  - mem_req, mem_we and iord are held stable until a rising edge at which mem_req && mem_ready.
  - mem_ready may be high in the first request cycle (zero-wait).
  - mem_ready while mem_req=0 is ignored.
- ir_we and the FETCH pc_we are Mealy outputs (gated by mem_ready). All other outputs are Moore.
- Cycles per instruction with zero-wait memory, each memory wait cycle adding 1:
  - lw 5
  - sw 4
  - R/I/LUI 4
  - beq/bne 3
  - jal 3
  - jalr 3
- rst asserted mid-instruction: immediate return to START. Partial state is discarded, and no write enable is asserted in the reset cycle.

## Configuration
- MULTICYCLE_CTRL_INSTRET_EN defined:
  - instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, JAL or JALR.
  - It wraps from 32'hFFFFFFFF to 0.
  - It never increments in HALT.
- Not defined: instret is constant 0 and the counter logic is absent.

## Test plan
- Reset, then zero-wait `addi x1,x0,5` (0x00500093): states 0,1,2,7,8,1. Write-back cycle shows reg_we=1, wb_sel=0, ula_op=00000. With the macro, instret=1.
- `lw x2,0(x1)` with mem_ready low for 3 cycles in MEMREAD: mem_req/iord=1 held for 4 cycles, then MEMWB with wb_sel=1. 8 cycles total.
- `beq x0,x0,+8` (zero=1): BRANCH asserts pc_we=1, pc_sel=1. `bne` with zero=1: pc_we=0 in BRANCH.
- `jalr x1,0(x1)`: JALR cycle shows pc_we=1, pc_sel=0, reg_we=1, wb_sel=2, alu_a_sel=2, alu_b_sel=2. `jal` takes 3 cycles.
- Illegal opcode 0x0000007F: DECODE→HALT, halted=1. No further mem_req until rst. instret unchanged.
- rst pulsed during MEMWRITE wait: state=0 and all outputs 0 asynchronously. The next instruction fetches normally.
